// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w: two combinational read ports, one synchronous write port.
// Holds X0..X30 in flops. X31 (XZR) has no storage and always reads zero.
// The storage is cleared asynchronously by reset, so it is kept in flops
// rather than in block RAM.
// With BYPASS=1, a read of the register being written this cycle returns
// BusW instead of the stored value.
module reg_file_2r1w #(
  parameter int WIDTH  = 64,
  parameter bit BYPASS = 1'b1
) (
  input  logic             Clk,
  input  logic             Reset_L,
  input  logic [4:0]       RA,
  input  logic [4:0]       RB,
  input  logic [4:0]       RW,
  input  logic [WIDTH-1:0] BusW,
  input  logic             RegWr,
  output logic [WIDTH-1:0] BusA,
  output logic [WIDTH-1:0] BusB
);

  localparam logic [4:0] XZR = 5'd31;

  // Stored values seen by the read muxes. Entry 31 is a constant zero,
  // so every 5-bit address lands on a defined entry.
  logic [WIDTH-1:0] w_regs [0:31];

  // One-hot write strobe per physical register. No strobe exists for X31,
  // so writes to XZR are dropped.
  logic [30:0]      w_wr_en;

  // The bypass applies only outside reset, so reads return 0 during reset.
  logic             w_byp_ok;
  logic [WIDTH-1:0] w_bus_a;
  logic [WIDTH-1:0] w_bus_b;

  assign w_byp_ok  = BYPASS && RegWr && Reset_L;
  assign w_regs[31] = '0;

  genvar gi;
  generate
    for (gi = 0; gi < 31; gi++) begin : g_reg
      logic [WIDTH-1:0] r_q;

      assign w_wr_en[gi] = RegWr && (RW == 5'(gi));

      // Register storage: cleared asynchronously by reset, loaded with BusW
      // on a strobed edge.
      always_ff @(posedge Clk or negedge Reset_L) begin
        if (!Reset_L) begin
          r_q <= '0;
        end else if (w_wr_en[gi]) begin
          r_q <= BusW;
        end
      end

      assign w_regs[gi] = r_q;
    end
  endgenerate

  // Port A read: XZR first, then the same-cycle bypass, then storage.
  always_comb begin
    w_bus_a = '0;
    if (RA != XZR) begin
      if (w_byp_ok && (RW == RA)) begin
        w_bus_a = BusW;
      end else begin
        w_bus_a = w_regs[RA];
      end
    end
  end

  // Port B read: the same rules as port A, using RB.
  always_comb begin
    w_bus_b = '0;
    if (RB != XZR) begin
      if (w_byp_ok && (RW == RB)) begin
        w_bus_b = BusW;
      end else begin
        w_bus_b = w_regs[RB];
      end
    end
  end

  assign BusA = w_bus_a;
  assign BusB = w_bus_b;

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Testbench for reg_file_2r1w. It drives one stimulus stream into two
// instances, one with BYPASS=1 and one with BYPASS=0.
// Expected read values are pushed to a scoreboard queue when the inputs are
// driven. They are popped and compared once the combinational reads settle.
module tb_reg_file_2r1w;

  localparam int W = 64;

  logic          Clk;
  logic          Reset_L;
  logic [4:0]    RA;
  logic [4:0]    RB;
  logic [4:0]    RW;
  logic [W-1:0]  BusW;
  logic          RegWr;
  logic [W-1:0]  byp_a;
  logic [W-1:0]  byp_b;
  logic [W-1:0]  nb_a;
  logic [W-1:0]  nb_b;

  int n_checks = 0;
  int n_errors = 0;

  // Port index: 0 = bypass A, 1 = bypass B, 2 = no-bypass A, 3 = no-bypass B.
  typedef struct {
    string        tag;
    int           port;
    logic [W-1:0] exp;
  } exp_t;

  exp_t sb_q[$];

  // Reference contents of the architectural registers.
  logic [W-1:0] mdl [0:31];

  reg_file_2r1w #(.WIDTH(W), .BYPASS(1'b1)) dut_byp (
    .Clk(Clk), .Reset_L(Reset_L), .RA(RA), .RB(RB), .RW(RW),
    .BusW(BusW), .RegWr(RegWr), .BusA(byp_a), .BusB(byp_b)
  );

  reg_file_2r1w #(.WIDTH(W), .BYPASS(1'b0)) dut_nb (
    .Clk(Clk), .Reset_L(Reset_L), .RA(RA), .RB(RB), .RW(RW),
    .BusW(BusW), .RegWr(RegWr), .BusA(nb_a), .BusB(nb_b)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference register contents: zero in reset, updated on enabled edges.
  always @(posedge Clk or negedge Reset_L) begin
    if (!Reset_L) begin
      for (int i = 0; i < 32; i++) mdl[i] <= '0;
    end else if (RegWr && RW != 5'd31) begin
      mdl[RW] <= BusW;
    end
  end

  task automatic check_eq(input string tag, input logic [W-1:0] got,
                          input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] observe(input int port);
    case (port)
      0:       return byp_a;
      1:       return byp_b;
      2:       return nb_a;
      default: return nb_b;
    endcase
  endfunction

  task automatic expect_val(input string tag, input int port,
                            input logic [W-1:0] v);
    exp_t e;
    e.tag  = tag;
    e.port = port;
    e.exp  = v;
    sb_q.push_back(e);
  endtask

  // Allow the reads to settle, then compare every pending expectation.
  task automatic drain();
    exp_t e;
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_eq(e.tag, observe(e.port), e.exp);
      $display("check %-14s port=%0d got=%h exp=%h", e.tag, e.port,
               observe(e.port), e.exp);
    end
  endtask

  // Expected read value for one address, computed from the reference model.
  function automatic logic [W-1:0] ref_read(input logic [4:0] a, input bit byp);
    if (a == 5'd31) return '0;
    if (!Reset_L) return '0;
    if (byp && RegWr && RW == a) return BusW;
    return mdl[a];
  endfunction

  // Write one register over a single edge, with the read addresses unchanged.
  task automatic do_write(input logic [4:0] addr, input logic [W-1:0] data);
    @(negedge Clk);
    RegWr = 1'b1;
    RW    = addr;
    BusW  = data;
    @(posedge Clk);
    #1;
    RegWr = 1'b0;
  endtask

  initial begin
    Reset_L = 1'b0;
    RegWr   = 1'b0;
    RA      = 5'd0;
    RB      = 5'd30;
    RW      = 5'd0;
    BusW    = '0;

    // Reset state.
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    expect_val("rst_a", 0, '0);
    expect_val("rst_b", 1, '0);
    expect_val("rst_nb_b", 3, '0);
    drain();
    Reset_L = 1'b1;

    // Preload X5, then assert reset mid-cycle with no clock edge.
    do_write(5'd5, 64'h1234);
    RA = 5'd5;
    expect_val("preload_x5", 0, 64'h1234);
    expect_val("preload_x5_nb", 2, 64'h1234);
    drain();
    Reset_L = 1'b0;
    expect_val("async_rst", 0, '0);
    expect_val("async_rst_nb", 2, '0);
    drain();

    // A write attempted while reset is held is lost, and the bypass is off.
    @(negedge Clk);
    RegWr = 1'b1;
    RW    = 5'd5;
    BusW  = 64'hFF;
    expect_val("rst_nobyp", 0, '0);
    drain();
    @(posedge Clk);
    @(negedge Clk);
    RegWr = 1'b0;
    Reset_L = 1'b1;
    expect_val("rst_wr_lost", 0, '0);
    expect_val("rst_wr_lost_nb", 2, '0);
    drain();

    // Write and read back at full width.
    do_write(5'd1, 64'hDEADBEEF_00000001);
    do_write(5'd30, 64'hFFFFFFFF_FFFFFFFF);
    @(negedge Clk);
    RA = 5'd1;
    RB = 5'd30;
    expect_val("rd_x1", 0, 64'hDEADBEEF_00000001);
    expect_val("rd_x30", 1, 64'hFFFFFFFF_FFFFFFFF);
    expect_val("rd_x1_nb", 2, 64'hDEADBEEF_00000001);
    expect_val("rd_x30_nb", 3, 64'hFFFFFFFF_FFFFFFFF);
    drain();

    // Back-to-back writes to the same register: the last write wins.
    do_write(5'd2, 64'hAAAA);
    do_write(5'd2, 64'hBBBB);
    @(negedge Clk);
    RA = 5'd2;
    RB = 5'd2;
    expect_val("b2b_a", 0, 64'hBBBB);
    expect_val("b2b_b", 1, 64'hBBBB);
    drain();

    // XZR: a write to X31 is dropped, and the bypass does not apply to it.
    @(negedge Clk);
    RegWr = 1'b1;
    RW    = 5'd31;
    BusW  = 64'h55;
    RA    = 5'd31;
    RB    = 5'd31;
    expect_val("xzr_byp_a", 0, '0);
    expect_val("xzr_byp_b", 1, '0);
    drain();
    @(posedge Clk);
    @(negedge Clk);
    RegWr = 1'b0;
    expect_val("xzr_a", 0, '0);
    expect_val("xzr_b", 1, '0);
    expect_val("xzr_nb_a", 2, '0);
    drain();

    // Same-cycle write and read of X7, with and without the bypass.
    do_write(5'd7, 64'h10);
    @(negedge Clk);
    RegWr = 1'b1;
    RW    = 5'd7;
    BusW  = 64'h20;
    RA    = 5'd7;
    expect_val("byp_pre", 0, 64'h20);
    expect_val("nobyp_pre", 2, 64'h10);
    drain();
    @(posedge Clk);
    @(negedge Clk);
    RegWr = 1'b0;
    expect_val("byp_post", 0, 64'h20);
    expect_val("nobyp_post", 2, 64'h20);
    drain();

    // With the write enable low, no register changes.
    @(negedge Clk);
    RegWr = 1'b0;
    RW    = 5'd3;
    BusW  = 64'hAB;
    @(posedge Clk);
    @(negedge Clk);
    RA = 5'd3;
    RB = 5'd3;
    expect_val("wen_low_a", 0, '0);
    expect_val("wen_low_b", 1, '0);
    expect_val("wen_low_nb", 3, '0);
    drain();

    // Random traffic checked against the reference model. About half of the
    // cycles read the address being written, to exercise the bypass.
    for (int it = 0; it < 60; it++) begin
      @(negedge Clk);
      RegWr = 1'($urandom_range(0, 1));
      RW    = 5'($urandom_range(0, 31));
      BusW  = {$urandom, $urandom};
      RA    = ($urandom_range(0, 1) == 1) ? RW : 5'($urandom_range(0, 31));
      RB    = ($urandom_range(0, 1) == 1) ? RW : 5'($urandom_range(0, 31));
      expect_val("rnd_byp_a", 0, ref_read(RA, 1'b1));
      expect_val("rnd_byp_b", 1, ref_read(RB, 1'b1));
      expect_val("rnd_nb_a", 2, ref_read(RA, 1'b0));
      expect_val("rnd_nb_b", 3, ref_read(RB, 1'b0));
      drain();
    end

    @(negedge Clk);
    RegWr = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/reg_file_2r1w.md
# reg_file_2r1w

Two-read, one-write register file holding the datapath's general-purpose registers. It sources the two operand buses: BusA feeds the ALU directly, and BusB feeds the first input of the ALUSrc 2:1 mux, whose second input is the sign-extended immediate. Writes are synchronous on the rising clock edge. Reads are combinational, with an optional same-cycle write bypass. Register 31 is hardwired zero (XZR).

## Interface
- WIDTH, 64, data width of each register and of every bus
- BYPASS, 1, 1 = a read of the register being written this cycle returns BusW; 0 = it returns the stored (old) value
- Clk  input  1  clock; all writes on rising edge
- Reset_L  input  1  reset, asynchronous, active-low; clears all registers
- RA  input  5  read address, port A
- RB  input  5  read address, port B
- RW  input  5  write address
- BusW  input  WIDTH  write data
- RegWr  input  1  write enable, sampled on rising Clk
- BusA  output  WIDTH  read data, port A
- BusB  output  WIDTH  read data, port B (to ALUSrc mux input 0)

## Operation
- Storage: 31 physical registers, X0..X30, each WIDTH bits. X31 has no storage.
- Reset:
  - Reset_L low asynchronously forces X0..X30 to 0, immediately, without waiting for a clock edge.
  - All registers hold 0 while Reset_L is low.
  - BusA and BusB therefore read 0 for every address during reset.
- Write:
  - On a rising Clk with Reset_L high, RegWr=1 and RW!=31, register[RW] <= BusW.
  - RegWr=0 or RW=31: no register changes.
- Read A:
  - RA==31 gives BusA=0.
  - Otherwise, when BYPASS=1, RegWr=1, RW==RA and Reset_L=1, BusA=BusW.
  - Otherwise BusA=register[RA].
- Read B: identical rules using RB.
- Both read ports are independent. RA==RB is legal, and both ports then return the same value.
- Read of X31 returns 0 even when RW=31 with RegWr=1 and bypass is enabled.
- No arithmetic. Data passes through unmodified, with full WIDTH and no truncation.

## Timing
- Write latency: 1 edge. Data presented before edge k is readable from the non-bypass path immediately after edge k.
- Read latency: 0 cycles, purely combinational from RA/RB, register contents and (if BYPASS) RW/RegWr/BusW.
- Reset assert: registers clear asynchronously, with no edge required.
- Reset deassert: the first write takes effect at the first rising Clk at which Reset_L is sampled high.
- Reset mid-write: if Reset_L falls in the same cycle as a pending write, the write is lost and the register reads 0.
- Simultaneous read and write of the same register:
  - BYPASS=1: the read sees the new value in the write cycle.
  - BYPASS=0: the read sees the old value until after the edge.
- Back-to-back writes to the same RW on consecutive edges: the last one wins. No hazard logic is internal to the block.

## Test plan
- Reset: preload X5=64'h1234, then drop Reset_L mid-cycle with no Clk edge -> BusA (RA=5) reads 0 immediately. With Reset_L still low, RegWr=1, RW=5, BusW=64'hFF plus one edge -> X5 still 0.
- Write/readback:
  - Write X1=64'hDEADBEEF_00000001 and X30=64'hFFFFFFFF_FFFFFFFF on successive edges.
  - RA=1, RB=30 -> BusA=64'hDEADBEEF_00000001, BusB=64'hFFFFFFFF_FFFFFFFF.
- XZR:
  - RegWr=1, RW=31, BusW=64'h55 plus edge, then RA=RB=31 -> both buses 0.
  - During the same write cycle with BYPASS=1 -> BusA=0.
- Bypass (BYPASS=1):
  - Set X7=64'h10.
  - Next cycle, with RegWr=1, RW=7, BusW=64'h20 and RA=7, before the edge -> BusA=64'h20.
  - After the edge with RegWr=0 -> BusA=64'h20.
- No bypass (BYPASS=0 instance): same stimulus as the bypass test -> BusA=64'h10 before the edge and 64'h20 after it.
- Write enable low:
  - RegWr=0, RW=3, BusW=64'hAB plus edge -> X3 remains 0.
  - RA=RB=3 -> BusA=BusB=0.
